// File: rtl/hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// hazard_detection_unit
//
// Stall/flush controller for a 5-stage MIPS pipeline.
//
// It handles the hazards that operand forwarding cannot resolve:
//   - load-use
//   - branch operands compared in ID
//   - taken-branch flush
//   - data-memory wait states
//
// A small FSM tracks memory wait states and raises a sticky timeout. A
// saturating counter records how many cycles the PC was held.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   rs_IF_ID, rt_IF_ID  source registers of the instruction in ID
//   uses_rt_IF_ID       the ID instruction reads rt as a source
//   Branch_ID           the ID instruction is a branch
//   BranchTaken_ID      branch comparison result in ID
//   rt_ID_EX            load destination of the EX instruction
//   rd_ID_EX            ALU destination of the EX instruction
//   MemRead_ID_EX       the EX instruction is a load
//   RegWrite_ID_EX      the EX instruction writes a register
//   rd_EX_MEM           destination of the MEM instruction
//   MemRead_EX_MEM      the MEM instruction is a load
//   mem_busy            data memory not ready this cycle
//   stall_count_clr     clear stall_count
//   PCWrite             PC update enable
//   IF_ID_Write         IF_ID register enable
//   ID_EX_Bubble        zero the ID_EX control fields
//   IF_ID_Flush         replace the IF_ID contents with a NOP
//   pipe_freeze         hold ID_EX, EX_MEM and MEM_WB
//   mem_timeout         sticky memory timeout flag (registered)
//   stall_count         saturating count of cycles with PCWrite=0 (registered)
// ---------------------------------------------------------------------------
module hazard_detection_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             rs_IF_ID,
  input  logic [4:0]             rt_IF_ID,
  input  logic                   uses_rt_IF_ID,
  input  logic                   Branch_ID,
  input  logic                   BranchTaken_ID,
  input  logic [4:0]             rt_ID_EX,
  input  logic [4:0]             rd_ID_EX,
  input  logic                   MemRead_ID_EX,
  input  logic                   RegWrite_ID_EX,
  input  logic [4:0]             rd_EX_MEM,
  input  logic                   MemRead_EX_MEM,
  input  logic                   mem_busy,
  input  logic                   stall_count_clr,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   ID_EX_Bubble,
  output logic                   IF_ID_Flush,
  output logic                   pipe_freeze,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic                   mem_timeout_reg, mem_timeout_next;
  logic [STALL_CNT_W-1:0] stall_count_reg, stall_count_next;

  logic lu, br_alu, br_ld, stall, freeze;

  // Register 0 is hard-wired to zero, so a dependency on it is never a hazard.
  function automatic logic reg_dep(input logic [4:0] dst, input logic [4:0] src);
    return (src != 5'd0) && (dst == src);
  endfunction

  assign lu = MemRead_ID_EX &
              (reg_dep(rt_ID_EX, rs_IF_ID) |
               (uses_rt_IF_ID & reg_dep(rt_ID_EX, rt_IF_ID)));

  // A load in EX is already covered by lu. It must not double up as an ALU
  // dependency here, because its data only arrives after MEM.
  assign br_alu = Branch_ID & RegWrite_ID_EX & ~MemRead_ID_EX &
                  (reg_dep(rd_ID_EX, rs_IF_ID) | reg_dep(rd_ID_EX, rt_IF_ID));

  assign br_ld = Branch_ID & MemRead_EX_MEM &
                 (reg_dep(rd_EX_MEM, rs_IF_ID) | reg_dep(rd_EX_MEM, rt_IF_ID));

  assign stall = lu | br_alu | br_ld;

  // Freeze tracks mem_busy directly, so it drops in the same cycle that the
  // memory becomes ready. TIMEOUT freezes unconditionally.
  always_comb begin
    freeze = 1'b0;
    case (state_reg)
      ST_RUN, ST_MEM_WAIT: freeze = mem_busy;
      ST_TIMEOUT:          freeze = 1'b1;
      default:             freeze = mem_busy;
    endcase
  end

  // Pipeline control outputs. Priority is freeze, then stall, then taken
  // branch. A stalled taken branch is therefore only flushed once the stall
  // clears.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst) begin
      if (freeze) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        pipe_freeze = 1'b1;
      end else if (stall) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if (Branch_ID && BranchTaken_ID) begin
        IF_ID_Flush = 1'b1;
      end
    end
  end

  // Memory-wait FSM. wait_cnt holds the number of consecutive busy cycles
  // already seen.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (mem_busy) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next       = ST_TIMEOUT;
          mem_timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_ONE;
        end
      end
      ST_TIMEOUT: begin
        // Only reset leaves this state.
        state_next = ST_TIMEOUT;
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // The clear request wins over the increment. The count saturates at all-ones.
  always_comb begin
    stall_count_next = stall_count_reg;
    if (stall_count_clr) begin
      stall_count_next = '0;
    end else if (!PCWrite && (stall_count_reg != CNT_MAX)) begin
      stall_count_next = stall_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CW      = 3;
  localparam int CNT_MAX    = (1 << TB_CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs_IF_ID = '0, rt_IF_ID = '0, rt_ID_EX = '0, rd_ID_EX = '0, rd_EX_MEM = '0;
  logic uses_rt_IF_ID = 0, Branch_ID = 0, BranchTaken_ID = 0, MemRead_ID_EX = 0;
  logic RegWrite_ID_EX = 0, MemRead_EX_MEM = 0, mem_busy = 0, stall_count_clr = 0;
  logic PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze, mem_timeout;
  logic [TB_CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.MEM_TIMEOUT(TB_TIMEOUT), .STALL_CNT_W(TB_CW)) dut (
    .clk(clk), .rst(rst),
    .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
    .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID),
    .rt_ID_EX(rt_ID_EX), .rd_ID_EX(rd_ID_EX),
    .MemRead_ID_EX(MemRead_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX),
    .rd_EX_MEM(rd_EX_MEM), .MemRead_EX_MEM(MemRead_EX_MEM),
    .mem_busy(mem_busy), .stall_count_clr(stall_count_clr),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  // ---------------- reference model ----------------
  // State: length of the current busy run, timed-out flag, stall total.
  int busy_run = 0;
  bit timed_out = 0;
  int held_cycles = 0;

  logic m_stall, m_frz;
  logic e_pcw, e_ifw, e_bub, e_fl, e_frz;
  logic [TB_CW-1:0] held_v;

  function automatic bit depends(input logic [4:0] producer, input logic [4:0] src);
    return (src != 0) && (producer == src);
  endfunction

  always_comb begin
    m_stall = 1'b0;
    if (MemRead_ID_EX && depends(rt_ID_EX, rs_IF_ID)) m_stall = 1'b1;
    if (MemRead_ID_EX && uses_rt_IF_ID && depends(rt_ID_EX, rt_IF_ID)) m_stall = 1'b1;
    if (Branch_ID && RegWrite_ID_EX && !MemRead_ID_EX &&
        (depends(rd_ID_EX, rs_IF_ID) || depends(rd_ID_EX, rt_IF_ID))) m_stall = 1'b1;
    if (Branch_ID && MemRead_EX_MEM &&
        (depends(rd_EX_MEM, rs_IF_ID) || depends(rd_EX_MEM, rt_IF_ID))) m_stall = 1'b1;
    m_frz = timed_out || mem_busy;
    {e_pcw, e_ifw, e_bub, e_fl, e_frz} = 5'b11000;
    if (!rst) begin
      if (m_frz)                            {e_pcw, e_ifw, e_bub, e_fl, e_frz} = 5'b00001;
      else if (m_stall)                     {e_pcw, e_ifw, e_bub, e_fl, e_frz} = 5'b00100;
      else if (Branch_ID && BranchTaken_ID) {e_pcw, e_ifw, e_bub, e_fl, e_frz} = 5'b11010;
    end
    held_v = held_cycles[TB_CW-1:0];
  end

  always @(posedge clk) begin
    if (rst) begin
      busy_run    <= 0;
      timed_out   <= 0;
      held_cycles <= 0;
    end else begin
      if (stall_count_clr) held_cycles <= 0;
      else if (!e_pcw && held_cycles < CNT_MAX) held_cycles <= held_cycles + 1;
      if (!timed_out) begin
        if (mem_busy) begin
          busy_run <= busy_run + 1;
          if (busy_run + 1 >= TB_TIMEOUT) timed_out <= 1;
        end else begin
          busy_run <= 0;
        end
      end
    end
  end

  wire [6+TB_CW-1:0] obs  = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze,
                             mem_timeout, stall_count};
  wire [6+TB_CW-1:0] expv = {e_pcw, e_ifw, e_bub, e_fl, e_frz, timed_out, held_v};

  task automatic clear_inputs();
    rs_IF_ID = 0; rt_IF_ID = 0; rt_ID_EX = 0; rd_ID_EX = 0; rd_EX_MEM = 0;
    uses_rt_IF_ID = 0; Branch_ID = 0; BranchTaken_ID = 0; MemRead_ID_EX = 0;
    RegWrite_ID_EX = 0; MemRead_EX_MEM = 0; mem_busy = 0; stall_count_clr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1; MemRead_ID_EX = 1; rt_ID_EX = 1; rs_IF_ID = 1; mem_busy = 1;
    #1;
    total++;
    if ({PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=11000",
               {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, pipe_freeze});
    end
    @(negedge clk);
    rst = 0; clear_inputs();
    #1;
    total++;
    if (stall_count !== 0 || mem_timeout !== 0) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d to=%b exp cnt=0 to=0", stall_count, mem_timeout);
    end
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL reset_vec got=%b exp=%b", obs, expv);
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_inputs();
      case (c)
        0: stall_count_clr = 1;
        1: begin MemRead_ID_EX = 1; rt_ID_EX = 1; rs_IF_ID = 1; end
        3: begin MemRead_ID_EX = 1; uses_rt_IF_ID = 1; end
        default: ;
      endcase
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL load_use_vec cyc=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c == 1) begin
        total++;
        if ({PCWrite, IF_ID_Write, ID_EX_Bubble} !== 3'b001) begin
          bad++;
          $display("FAIL load_use_stall got=%b exp=001", {PCWrite, IF_ID_Write, ID_EX_Bubble});
        end
      end
      if (c == 2 || c == 4) begin
        total++;
        if (stall_count !== 1 || PCWrite !== 1) begin
          bad++;
          $display("FAIL load_use_count cyc=%0d got cnt=%0d pcw=%b exp cnt=1 pcw=1",
                   c, stall_count, PCWrite);
        end
      end
    end
  endtask

  task automatic test_branch_after_load();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c >= 1 && c <= 3) begin Branch_ID = 1; BranchTaken_ID = 1; rs_IF_ID = 4; end
      case (c)
        0: stall_count_clr = 1;
        1: begin MemRead_ID_EX = 1; rt_ID_EX = 4; end
        2: begin MemRead_EX_MEM = 1; rd_EX_MEM = 4; end
        default: ;
      endcase
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL br_load_vec cyc=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c == 1 || c == 2) begin
        total++;
        if ({PCWrite, ID_EX_Bubble, IF_ID_Flush} !== 3'b010) begin
          bad++;
          $display("FAIL br_load_stall cyc=%0d got=%b exp=010", c, {PCWrite, ID_EX_Bubble, IF_ID_Flush});
        end
      end
      if (c == 3) begin
        total++;
        if ({PCWrite, IF_ID_Write, IF_ID_Flush} !== 3'b111) begin
          bad++;
          $display("FAIL br_load_flush got=%b exp=111", {PCWrite, IF_ID_Write, IF_ID_Flush});
        end
      end
      if (c == 4) begin
        total++;
        if (stall_count !== 2) begin
          bad++;
          $display("FAIL br_load_count got=%0d exp=2", stall_count);
        end
      end
    end
  endtask

  task automatic test_branch_alu();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_inputs();
      RegWrite_ID_EX = 1; rd_ID_EX = 6; rt_IF_ID = 6; rs_IF_ID = 2;
      case (c)
        0: Branch_ID = 1;
        1: Branch_ID = 0;
        2: begin Branch_ID = 1; MemRead_ID_EX = 1; rt_ID_EX = 9; uses_rt_IF_ID = 1; end
        default: begin Branch_ID = 1; rd_ID_EX = 0; rs_IF_ID = 0; rt_IF_ID = 5; end
      endcase
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL br_alu_vec cyc=%0d got=%b exp=%b", c, obs, expv);
      end
      total++;
      if (ID_EX_Bubble !== (c == 0)) begin
        bad++;
        $display("FAIL br_alu_bubble cyc=%0d got=%b exp=%b", c, ID_EX_Bubble, (c == 0));
      end
    end
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) stall_count_clr = 1;
      if (c >= 1 && c <= 4) begin MemRead_ID_EX = 1; rt_ID_EX = 1; rs_IF_ID = 1; end
      if (c >= 1 && c <= 3) mem_busy = 1;
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL mem_wait_vec cyc=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c >= 1 && c <= 4) begin
        total++;
        if ({pipe_freeze, ID_EX_Bubble} !== ((c <= 3) ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL mem_wait_ctl cyc=%0d got=%b exp=%b", c, {pipe_freeze, ID_EX_Bubble},
                   ((c <= 3) ? 2'b10 : 2'b01));
        end
      end
      if (c == 5) begin
        total++;
        if (stall_count !== 4 || mem_timeout !== 0) begin
          bad++;
          $display("FAIL mem_wait_count got cnt=%0d to=%b exp cnt=4 to=0", stall_count, mem_timeout);
        end
      end
    end
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c <= 4) mem_busy = 1;
      rst = (c == 6);
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL timeout_vec cyc=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c == 4) begin
        total++;
        if (mem_timeout !== 0) begin
          bad++;
          $display("FAIL timeout_early got=%b exp=0", mem_timeout);
        end
      end
      if (c == 5) begin
        total++;
        if (mem_timeout !== 1 || pipe_freeze !== 1) begin
          bad++;
          $display("FAIL timeout_sticky got to=%b frz=%b exp to=1 frz=1", mem_timeout, pipe_freeze);
        end
      end
      if (c == 7) begin
        total++;
        if ({pipe_freeze, mem_timeout, PCWrite} !== 3'b001) begin
          bad++;
          $display("FAIL timeout_reset got=%b exp=001", {pipe_freeze, mem_timeout, PCWrite});
        end
      end
    end
    rst = 0;
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0 || c == 10) stall_count_clr = 1;
      if (c >= 1 && c <= 11) begin MemRead_ID_EX = 1; rt_ID_EX = 3; rs_IF_ID = 3; end
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL sat_vec cyc=%0d got=%b exp=%b", c, obs, expv);
      end
      if (c >= 10) begin
        total++;
        if (stall_count !== ((c == 10) ? 3'd7 : (c == 11) ? 3'd0 : 3'd1)) begin
          bad++;
          $display("FAIL sat_count cyc=%0d got=%0d exp=%0d", c, stall_count,
                   ((c == 10) ? 7 : (c == 11) ? 0 : 1));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 49) == 0);
      rs_IF_ID        = 5'($urandom_range(0, 3));
      rt_IF_ID        = 5'($urandom_range(0, 3));
      rt_ID_EX        = 5'($urandom_range(0, 3));
      rd_ID_EX        = 5'($urandom_range(0, 3));
      rd_EX_MEM       = 5'($urandom_range(0, 3));
      uses_rt_IF_ID   = 1'($urandom_range(0, 1));
      Branch_ID       = 1'($urandom_range(0, 1));
      BranchTaken_ID  = 1'($urandom_range(0, 1));
      MemRead_ID_EX   = 1'($urandom_range(0, 1));
      RegWrite_ID_EX  = 1'($urandom_range(0, 1));
      MemRead_EX_MEM  = 1'($urandom_range(0, 1));
      mem_busy        = mem_busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
      stall_count_clr = ($urandom_range(0, 29) == 0);
      #1;
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL random_vec i=%0d got=%b exp=%b", i, obs, expv);
      end
    end
    @(negedge clk);
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_branch_alu();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
